// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state encoding, funct3 codes and access-size helper
// for the data-memory access stage.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Low two bits of funct3 encode log2 of the access size in bytes.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signals of the
// access stage; slave is the unit, master is the control unit plus memory.
interface mem_access_unit_if #(parameter int XLEN = 64) ();
  logic            req;
  logic            we;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            done;
  logic            err;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_wr;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - byte-lane extraction with extension for loads
// and read-modify-write merge for sub-doubleword stores (little-endian).
module lane_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] lane_mask;

  always_comb begin
    shamt = {offset, 3'b000};
    lane  = mem_rdata >> shamt;

    case (size_bytes(funct3))
      4'd1:    size_mask = XLEN'(8'hFF);
      4'd2:    size_mask = XLEN'(16'hFFFF);
      4'd4:    size_mask = XLEN'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase

    lane_mask  = size_mask << shamt;
    merge_data = (mem_rdata & ~lane_mask) | ((wdata & size_mask) << shamt);

    case (funct3)
      F3_B:    load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_W:    load_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_WU:   load_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store stage between the multicycle
// datapath and the doubleword data memory; FSM, latency counter and result registers.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int XLEN   = 64
) (
  input  logic clk,
  input  logic rst,
  mem_access_unit_if.slave bus
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t          state, state_next;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            err_q;

  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic            bad;
  logic            cnt_zero;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;

  assign accept   = (state == IDLE) && bus.req;
  assign cnt_zero = (cnt == '0);

  // Errors are judged on the live request so a bad access never reaches memory.
  always_comb begin
    illegal = (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
      2'b11:   misaligned = (bus.addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
    bad = illegal || misaligned;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (bad)                                  state_next = RESP;
          else if (bus.we && bus.funct3 == F3_D)    state_next = WRITE;
          else                                      state_next = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt_zero) state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.we;
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      cnt     <= CW'(RD_LAT - 1);
      rdata_q <= '0;
      err_q   <= bad;
      if (!bad && bus.we && bus.funct3 == F3_D) mem_wdata_q <= bus.wdata;
    end else if (state == RD_WAIT) begin
      if (cnt_zero) begin
        if (we_q) mem_wdata_q <= merge_data;
        else      rdata_q     <= load_data;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  lane_align #(.XLEN(XLEN)) u_lane_align (
    .offset     (addr_q[2:0]),
    .funct3     (f3_q),
    .mem_rdata  (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    bus.ready     = (state == IDLE);
    bus.mem_wr    = (state == WRITE);
    bus.done      = (state == RESP);
    bus.err       = err_q;
    bus.rdata     = rdata_q;
    bus.mem_addr  = {addr_q[XLEN-1:3], 3'b000};
    bus.mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and random loads/stores against a byte-level
// reference memory model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int RD_LAT = 1;
  localparam int XLEN   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_access_unit_if #(.XLEN(XLEN)) bus ();

  mem_access_unit #(.RD_LAT(RD_LAT), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem     [64];
  logic [63:0] ref_mem [64];
  int errors = 0;
  int checks = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[8:3]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output logic e_err, output logic [63:0] e_rdata,
                       output int e_lat, output logic e_write);
    int n;
    logic [63:0] b;
    logic [63:0] val;
    n       = 1 << f3[1:0];
    e_err   = (f3 == 3'b111) || (w && f3 >= 3'd4) || ((a % 64'(n)) != 0);
    e_rdata = '0;
    e_write = 1'b0;
    if (e_err) begin
      e_lat = 1;
    end else if (!w) begin
      val = '0;
      for (int i = 0; i < n; i++) begin
        b   = a + 64'(i);
        val = val | (64'(ref_mem[b[8:3]][{b[2:0], 3'b000} +: 8]) << (8 * i));
      end
      if (f3 < 3'd4 && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      e_rdata = val;
      e_lat   = RD_LAT + 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        b = a + 64'(i);
        ref_mem[b[8:3]][{b[2:0], 3'b000} +: 8] = wd[8*i +: 8];
      end
      e_write = 1'b1;
      e_lat   = (n == 8) ? 2 : RD_LAT + 2;
    end
  endtask

  task automatic run_access(input string tag, input logic w, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] wd, input bit hold_req,
                            output logic [63:0] got_rdata);
    logic        e_err, e_write, got_err;
    logic [63:0] e_rdata, wr_addr, wr_data;
    int          e_lat, lat, wr_n;
    bit          done_seen;
    model(w, f3, a, wd, e_err, e_rdata, e_lat, e_write);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    if (hold_req) begin
      bus.addr  = a ^ 64'h40;
      bus.wdata = ~wd;
    end else begin
      bus.req = 1'b0;
    end
    lat = 0; wr_n = 0; done_seen = 0; got_err = 1'b0; got_rdata = '0;
    wr_addr = '0; wr_data = '0;
    for (int c = 1; c <= 20 && !done_seen; c++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        wr_n++;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
        mem[bus.mem_addr[8:3]] = bus.mem_wdata;
      end
      if (bus.done) begin
        done_seen = 1;
        lat       = c;
        got_err   = bus.err;
        got_rdata = bus.rdata;
        bus.req   = 1'b0;
      end
    end
    check({tag, "_done_lat"}, 64'(lat), 64'(e_lat));
    check({tag, "_err"}, 64'(got_err), 64'(e_err));
    check({tag, "_wr_count"}, 64'(wr_n), e_write ? 64'd1 : 64'd0);
    if (e_write) begin
      check({tag, "_wr_addr"}, wr_addr, {a[63:3], 3'b000});
      check({tag, "_wr_data"}, wr_data, ref_mem[a[8:3]]);
    end else if (!w || e_err) begin
      check({tag, "_rdata"}, got_rdata, e_rdata);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
    check({tag, "_rdata_hold"}, bus.rdata, got_rdata);
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] a;
    logic [2:0]  f3;
    logic        w;
    int          wr_seen;

    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[32]     = 64'h8877_6655_4433_2211;
    ref_mem[32] = mem[32];

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.ready), 64'd1);
    check("post_rst_done", 64'(bus.done), 64'd0);
    check("post_rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("post_rst_rdata", bus.rdata, 64'd0);
    check("post_rst_mem_addr", bus.mem_addr, 64'd0);
    check("post_rst_err", 64'(bus.err), 64'd0);

    run_access("lb", 1'b0, F3_B, 64'h107, 64'd0, 0, r);
    check("lb_const", r, 64'hFFFF_FFFF_FFFF_FF88);
    run_access("lbu", 1'b0, F3_BU, 64'h107, 64'd0, 0, r);
    check("lbu_const", r, 64'h0000_0000_0000_0088);
    run_access("lw", 1'b0, F3_W, 64'h104, 64'd0, 0, r);
    check("lw_const", r, 64'hFFFF_FFFF_8877_6655);
    run_access("lwu", 1'b0, F3_WU, 64'h104, 64'd0, 0, r);
    check("lwu_const", r, 64'h0000_0000_8877_6655);
    run_access("ld", 1'b0, F3_D, 64'h100, 64'd0, 0, r);
    check("ld_const", r, 64'h8877_6655_4433_2211);
    run_access("lh", 1'b0, F3_H, 64'h106, 64'd0, 0, r);
    run_access("lhu", 1'b0, F3_HU, 64'h106, 64'd0, 0, r);
    run_access("sh", 1'b1, F3_H, 64'h102, 64'h0000_0000_0000_ABCD, 0, r);
    check("sh_mem", mem[32], 64'h8877_6655_ABCD_2211);
    run_access("sd", 1'b1, F3_D, 64'h108, 64'h0123_4567_89AB_CDEF, 0, r);
    check("sd_mem", mem[33], 64'h0123_4567_89AB_CDEF);
    run_access("sb", 1'b1, F3_B, 64'h10F, 64'h0000_0000_0000_005A, 0, r);
    run_access("sw", 1'b1, F3_W, 64'h10C, 64'hFFFF_FFFF_DEAD_BEEF, 0, r);
    run_access("lw_mis", 1'b0, F3_W, 64'h102, 64'd0, 0, r);
    run_access("f3_ill", 1'b0, 3'b111, 64'h100, 64'd0, 0, r);
    run_access("sbu_ill", 1'b1, F3_BU, 64'h100, 64'h55, 0, r);
    run_access("sd_mis", 1'b1, F3_D, 64'h104, 64'h1234, 0, r);
    run_access("busy_req", 1'b0, F3_D, 64'h108, 64'd0, 1, r);
    run_access("busy_st", 1'b1, F3_H, 64'h110, 64'h0000_0000_0000_7E01, 1, r);

    for (int k = 0; k < 60; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      run_access("rand", w, f3, a, {$urandom, $urandom}, bit'($urandom_range(0, 1)), r);
    end

    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = F3_H; bus.addr = 64'h10A; bus.wdata = 64'h1111;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.ready), 64'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("abort_mem_addr", bus.mem_addr, 64'd0);
    wr_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_wr) wr_seen++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_wr || bus.done) wr_seen++;
    end
    check("abort_no_write", 64'(wr_seen), 64'd0);

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
